chip8_alu_seq: RTL and testbench

CHIP8_ALU_SEQ -- requirements
Module: chip8_alu_seq

---
 rtl/chip8_alu_seq.sv | 165 ++++++++++++++++
 tb/tb_chip8_alu_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_alu_seq.sv
// chip8_alu_seq: CHIP-8 V0..VF register file plus a 5-state sequencer that runs 8xyN through an external ALU.
// Optional macro CHIP8_QUIRK_VF_RESET_EN: 8xy1/8xy2/8xy3 also clear VF.
package chip8_alu_pkg;
  typedef enum logic [2:0] {
    ALU_OR,
    ALU_AND,
    ALU_XOR,
    ALU_ADD,
    ALU_SUB,
    ALU_SHR,
    ALU_SHL
  } alu_op_t;
endpackage

module chip8_alu_seq
  import chip8_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_opcode,
  output logic        done,
  output logic        illegal,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_y,
  output alu_op_t     alu_op,
  input  logic [7:0]  alu_res,
  input  logic        alu_carry,
  input  logic [3:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

`ifdef CHIP8_QUIRK_VF_RESET_EN
  localparam logic LOGIC_CLEARS_VF = 1'b1;
`else
  localparam logic LOGIC_CLEARS_VF = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB_X, WB_F} state_t;

  state_t      state_reg, state_next;
  logic [11:0] opcode_reg;
  logic        illegal_reg;
  logic [7:0]  opa_reg, opb_reg, res_reg;
  logic        flag_we_reg, flag_val_reg;
  logic        flag_we_next, flag_val_next;
  logic        done_reg;
  logic        legal_cmd;
  logic        accept;
  logic [7:0]  v_reg [16];

  logic [3:0] x_idx, y_idx, n_code;
  assign x_idx  = opcode_reg[11:8];
  assign y_idx  = opcode_reg[7:4];
  assign n_code = opcode_reg[3:0];

  assign cmd_ready = (state_reg == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign illegal   = (state_reg == WB_F) && illegal_reg;
  assign done      = done_reg;
  assign dbg_data  = v_reg[dbg_addr];

  always_comb begin
    legal_cmd = 1'b0;
    if (cmd_opcode[15:12] == 4'h8) begin
      case (cmd_opcode[3:0])
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE: legal_cmd = 1'b1;
        default: legal_cmd = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid) state_next = legal_cmd ? READ : WB_F;
      READ:    state_next = EXEC;
      EXEC:    state_next = WB_X;
      WB_X:    state_next = WB_F;
      WB_F:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU drive and flag decision; operands come only from the READ-stage latches.
  always_comb begin
    alu_op        = ALU_OR;
    alu_x         = 8'd0;
    alu_y         = 8'd0;
    flag_we_next  = 1'b0;
    flag_val_next = 1'b0;
    if (state_reg == EXEC) begin
      case (n_code)
        4'h0: alu_y = opb_reg;
        4'h1: begin alu_op = ALU_OR;  alu_x = opa_reg; alu_y = opb_reg; flag_we_next = LOGIC_CLEARS_VF; end
        4'h2: begin alu_op = ALU_AND; alu_x = opa_reg; alu_y = opb_reg; flag_we_next = LOGIC_CLEARS_VF; end
        4'h3: begin alu_op = ALU_XOR; alu_x = opa_reg; alu_y = opb_reg; flag_we_next = LOGIC_CLEARS_VF; end
        4'h4: begin
          alu_op = ALU_ADD; alu_x = opa_reg; alu_y = opb_reg;
          flag_we_next = 1'b1; flag_val_next = alu_carry;
        end
        4'h5: begin
          alu_op = ALU_SUB; alu_x = opa_reg; alu_y = opb_reg;
          flag_we_next = 1'b1; flag_val_next = alu_carry;
        end
        4'h7: begin
          alu_op = ALU_SUB; alu_x = opb_reg; alu_y = opa_reg;
          flag_we_next = 1'b1; flag_val_next = alu_carry;
        end
        4'h6: begin
          alu_op = ALU_SHR; alu_x = opb_reg; alu_y = 8'd1;
          flag_we_next = 1'b1; flag_val_next = opb_reg[0];
        end
        4'hE: begin
          alu_op = ALU_SHL; alu_x = opb_reg; alu_y = 8'd1;
          flag_we_next = 1'b1; flag_val_next = opb_reg[7];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      opcode_reg   <= '0;
      illegal_reg  <= 1'b0;
      opa_reg      <= '0;
      opb_reg      <= '0;
      res_reg      <= '0;
      flag_we_reg  <= 1'b0;
      flag_val_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      // done follows WB_F so that the VF write is already visible when it pulses
      done_reg  <= (state_reg == WB_F) && !illegal_reg;
      if (accept) begin
        opcode_reg  <= cmd_opcode[11:0];
        illegal_reg <= !legal_cmd;
      end
      if (state_reg == READ) begin
        opa_reg <= v_reg[x_idx];
        opb_reg <= v_reg[y_idx];
      end
      if (state_reg == EXEC) begin
        res_reg      <= alu_res;
        flag_we_reg  <= flag_we_next;
        flag_val_reg <= flag_val_next;
      end
    end
  end

  // VF write lands after the Vx write, so a flag result wins when x = F.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) v_reg[i] <= '0;
    end else begin
      if (state_reg == WB_X) v_reg[x_idx] <= res_reg;
      if (state_reg == WB_F && !illegal_reg && flag_we_reg) v_reg[15] <= {7'd0, flag_val_reg};
    end
  end

endmodule

// File: tb/tb_chip8_alu_seq.sv
// Scoreboard bench for chip8_alu_seq: behavioural ALU, reference register file, queued expectations.
module tb_chip8_alu_seq;
  import chip8_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_opcode = 16'h0000;
  logic        done, illegal;
  logic [7:0]  alu_x, alu_y, alu_res;
  alu_op_t     alu_op;
  logic        alu_carry;
  logic [3:0]  dbg_addr = 4'd0;
  logic [7:0]  dbg_data;

  // load_en lets the bench's ALU return an arbitrary constant, used to preload V registers via 8x00
  logic        load_en = 1'b0;
  logic [7:0]  load_val = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    bit         ill;
    logic [3:0] x;
    logic [7:0] vx;
    logic [7:0] vf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_v [16];

  always #5 clk = ~clk;

  chip8_alu_seq dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .done(done), .illegal(illegal),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_res(alu_res),
    .alu_carry(alu_carry), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always_comb begin
    alu_res   = 8'h00;
    alu_carry = 1'b0;
    if (load_en) alu_res = load_val;
    else begin
      case (alu_op)
        ALU_OR:  alu_res = alu_x | alu_y;
        ALU_AND: alu_res = alu_x & alu_y;
        ALU_XOR: alu_res = alu_x ^ alu_y;
        ALU_ADD: {alu_carry, alu_res} = {1'b0, alu_x} + {1'b0, alu_y};
        ALU_SUB: begin alu_res = alu_x - alu_y; alu_carry = (alu_x >= alu_y); end
        ALU_SHR: alu_res = alu_x >> alu_y;
        ALU_SHL: alu_res = alu_x << alu_y;
        default: alu_res = 8'h00;
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expd);
    n_vec++;
    if (obs !== expd) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expd);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic run_op(input string tag, input logic [15:0] op, input bit ld, input logic [7:0] val);
    exp_t e, got;
    logic [7:0] vx, vy, r, f, d;
    bit fw, ill, seen;
    int lat;
    vx = ref_v[op[11:8]];
    vy = ref_v[op[7:4]];
    r = vx; f = ref_v[15]; fw = 0; ill = 0;
    if (op[15:12] != 4'h8) ill = 1;
    else if (ld) r = val;
    else begin
      case (op[3:0])
        4'h0: r = vy;
        4'h1: begin r = vx | vy; end
        4'h2: begin r = vx & vy; end
        4'h3: begin r = vx ^ vy; end
        4'h4: begin {f[0], r} = {1'b0, vx} + {1'b0, vy}; f[7:1] = 0; fw = 1; end
        4'h5: begin r = vx - vy; f = {7'd0, vx >= vy}; fw = 1; end
        4'h7: begin r = vy - vx; f = {7'd0, vy >= vx}; fw = 1; end
        4'h6: begin r = {1'b0, vy[7:1]}; f = {7'd0, vy[0]}; fw = 1; end
        4'hE: begin r = {vy[6:0], 1'b0}; f = {7'd0, vy[7]}; fw = 1; end
        default: ill = 1;
      endcase
`ifdef CHIP8_QUIRK_VF_RESET_EN
      if (op[3:0] inside {4'h1, 4'h2, 4'h3}) begin f = 8'h00; fw = 1; end
`endif
    end
    if (!ill) begin
      ref_v[op[11:8]] = r;
      if (fw) ref_v[15] = f;
    end
    e.tag = tag; e.ill = ill; e.x = op[11:8]; e.vx = ref_v[op[11:8]]; e.vf = ref_v[15];
    sb.push_back(e);

    @(negedge clk);
    load_en = ld; load_val = val;
    cmd_valid = 1'b1; cmd_opcode = op;
    check_val({tag, "_ready"}, 16'(cmd_ready), 16'h1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_opcode = 16'($urandom);
    lat = 1; seen = 0;
    while (lat <= 10 && !seen) begin
      if (done || illegal) seen = 1;
      else begin @(negedge clk); lat++; end
    end
    got = sb.pop_front();
    if (!seen) begin
      check_val({got.tag, "_timeout"}, 16'h0, 16'h1);
    end else begin
      check_val({got.tag, "_lat"}, 16'(lat), got.ill ? 16'd1 : 16'd5);
      check_val({got.tag, "_done"}, 16'(done), 16'(!got.ill));
      check_val({got.tag, "_illegal"}, 16'(illegal), 16'(got.ill));
      @(negedge clk);
      check_val({got.tag, "_pulse"}, 16'({done, illegal}), 16'h0);
      check_val({got.tag, "_alu_idle"}, {alu_x, alu_y}, 16'h0);
    end
    load_en = 1'b0;
    if (got.ill) begin
      for (int i = 0; i < 16; i++) begin
        rd(4'(i), d);
        check_val($sformatf("%s_v%0d", got.tag, i), 16'(d), 16'(ref_v[i]));
      end
    end else begin
      rd(got.x, d);
      check_val({got.tag, "_vx"}, 16'(d), 16'(got.vx));
      rd(4'hF, d);
      check_val({got.tag, "_vf"}, 16'(d), 16'(got.vf));
    end
    $display("op %s %h: vx=%h vf=%h ill=%0d", got.tag, op, got.vx, got.vf, got.ill);
  endtask

  initial begin
    logic [7:0] d;
    bit saw;
    for (int i = 0; i < 16; i++) ref_v[i] = 8'h00;

    #2;
    check_val("rst_ready", 16'(cmd_ready), 16'h1);
    check_val("rst_pulses", 16'({done, illegal}), 16'h0);
    check_val("rst_alu", {alu_x, alu_y}, 16'h0);
    check_val("rst_op", 16'(alu_op), 16'(ALU_OR));
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), d);
      check_val($sformatf("rst_v%0d", i), 16'(d), 16'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("ld_v1", 16'h8100, 1, 8'hF0);
    run_op("ld_v2", 16'h8200, 1, 8'h20);
    run_op("add",   16'h8124, 0, 8'h00);
    run_op("ld_v3", 16'h8300, 1, 8'h05);
    run_op("ld_v4", 16'h8400, 1, 8'h07);
    run_op("sub_borrow", 16'h8345, 0, 8'h00);
    run_op("ld_v3b", 16'h8300, 1, 8'h07);
    run_op("ld_v4b", 16'h8400, 1, 8'h05);
    run_op("sub_ok", 16'h8345, 0, 8'h00);
    run_op("ld_v5", 16'h8500, 1, 8'h81);
    run_op("shl", 16'h855E, 0, 8'h00);
    run_op("shr", 16'h8556, 0, 8'h00);
    run_op("ld_vf", 16'h8F00, 1, 8'h10);
    run_op("ld_v2b", 16'h8200, 1, 8'hFF);
    run_op("add_xf", 16'h8F24, 0, 8'h00);
    run_op("subn", 16'h8347, 0, 8'h00);
    run_op("copy", 16'h8630, 0, 8'h00);
    run_op("ld_v1c", 16'h8100, 1, 8'h3C);
    run_op("ld_v2c", 16'h8200, 1, 8'hA5);
    run_op("ld_vf1", 16'h8F00, 1, 8'h01);
    run_op("or", 16'h8121, 0, 8'h00);
    run_op("and", 16'h8722, 0, 8'h00);
    run_op("xor", 16'h8723, 0, 8'h00);
    run_op("ill_n", 16'h812F, 0, 8'h00);
    run_op("ill_top", 16'h1234, 0, 8'h00);

    run_op("ld_v1r", 16'h8100, 1, 8'h55);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 16'h8121;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_val("rst_mid_exec", 16'(alu_x), 16'h0055);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_ready", 16'(cmd_ready), 16'h1);
    check_val("rst_mid_alu", {alu_x, alu_y}, 16'h0);
    rd(4'h1, d);
    check_val("rst_mid_v1", 16'(d), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) ref_v[i] = 8'h00;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || illegal) saw = 1;
    end
    check_val("rst_mid_no_done", 16'(saw), 16'h0);
    rd(4'h1, d);
    check_val("rst_mid_v1_after", 16'(d), 16'h0);

    run_op("post_ld", 16'h8100, 1, 8'h90);
    run_op("post_add", 16'h8114, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
